// File: rtl/mpe_pkg.sv
// Shared defaults and FSM state encoding for the MPE psum collector.
package mpe_pkg;

  localparam int unsigned DATA_WIDTH_DEF = 32;
  localparam int unsigned NUMBER_PE_DEF  = 9;
  localparam int unsigned FIFO_DEPTH_DEF = 16;
  localparam int unsigned CNT_W_DEF      = 8;

  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_WAIT    = 2'd1;
  localparam logic [1:0] S_CAPTURE = 2'd2;
  localparam logic [1:0] S_DONE    = 2'd3;

endpackage

// File: rtl/psum_fifo.sv
// Synchronous first-word-fall-through FIFO with a registered head word.
// The head register keeps the last word seen once the FIFO drains.
module psum_fifo #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned DEPTH      = 16,
  localparam int unsigned PTR_W     = $clog2(DEPTH),
  localparam int unsigned CNT_W     = PTR_W + 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  push,
  input  logic                  pop,
  input  logic [DATA_WIDTH-1:0] din,
  output logic [DATA_WIDTH-1:0] head,
  output logic                  valid,
  output logic [CNT_W-1:0]      count,
  output logic                  full_c,
  output logic                  empty_c
);

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0]      rd_ptr;
  logic [PTR_W-1:0]      wr_ptr;
  logic [PTR_W-1:0]      rd_nxt;
  logic [PTR_W-1:0]      wr_nxt;
  logic [CNT_W-1:0]      cnt_nxt;
  logic [DATA_WIDTH-1:0] head_nxt;
  logic                  pop_ok;
  logic                  push_ok;

  // Next pointers, occupancy and head word; a full FIFO still accepts when popping.
  always_comb begin
    empty_c  = (count == '0);
    full_c   = (count == CNT_W'(DEPTH));
    pop_ok   = pop && !empty_c;
    push_ok  = push && (!full_c || pop_ok);
    rd_nxt   = pop_ok  ? rd_ptr + PTR_W'(1) : rd_ptr;
    wr_nxt   = push_ok ? wr_ptr + PTR_W'(1) : wr_ptr;
    cnt_nxt  = count;
    if (push_ok && !pop_ok) begin
      cnt_nxt = count + CNT_W'(1);
    end else if (!push_ok && pop_ok) begin
      cnt_nxt = count - CNT_W'(1);
    end
    // Only a push into a slot that becomes the new head bypasses the array.
    head_nxt = (push_ok && (wr_ptr == rd_nxt)) ? din : mem[rd_nxt];
  end

  // Pointer, count and head registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
      valid  <= 1'b0;
      head   <= '0;
    end else begin
      rd_ptr <= rd_nxt;
      wr_ptr <= wr_nxt;
      count  <= cnt_nxt;
      valid  <= (cnt_nxt != '0);
      if (cnt_nxt != '0) begin
        head <= head_nxt;
      end
    end
  end

  // Storage array, written only on an accepted push.
  always_ff @(posedge clk) begin
    if (push_ok) begin
      mem[wr_ptr] <= din;
    end
  end

endmodule

// File: rtl/mpe_psum_collector.sv
// Bottom-of-column psum drain: waits out the column fill latency after a
// start strobe, captures N consecutive psums into a FIFO and streams them out.
module mpe_psum_collector
  import mpe_pkg::*;
#(
  parameter int unsigned DATA_WIDTH    = DATA_WIDTH_DEF,
  parameter int unsigned NUMBER_PE     = NUMBER_PE_DEF,
  parameter int unsigned START_LATENCY = NUMBER_PE + 1,
  parameter int unsigned FIFO_DEPTH    = FIFO_DEPTH_DEF,
  parameter int unsigned CNT_W         = CNT_W_DEF,
  localparam int unsigned FCNT_W       = $clog2(FIFO_DEPTH) + 1
) (
  input  logic                  i_clk,
  input  logic                  i_rest_n,
  input  logic                  i_start,
  input  logic [CNT_W-1:0]      i_num_out,
  input  logic [DATA_WIDTH-1:0] i_psum,
  output logic [DATA_WIDTH-1:0] o_psum_data,
  output logic                  o_psum_valid,
  input  logic                  i_psum_ready,
  output logic                  o_busy,
  output logic                  o_done,
  output logic                  o_overflow,
  output logic [FCNT_W-1:0]     o_fifo_count
);

  // WAIT lasts START_LATENCY-1 cycles so the first capture lands on edge T0+START_LATENCY.
  localparam int unsigned WAIT_W    = (START_LATENCY > 2) ? $clog2(START_LATENCY) : 1;
  localparam int unsigned WAIT_LAST = (START_LATENCY >= 2) ? START_LATENCY - 2 : 0;

  logic [1:0]        state;
  logic [1:0]        state_nxt;
  logic [WAIT_W-1:0] wait_cnt;
  logic [WAIT_W-1:0] wait_nxt;
  logic [CNT_W-1:0]  cap_cnt;
  logic [CNT_W-1:0]  cap_nxt;
  logic [CNT_W-1:0]  num_q;
  logic [CNT_W-1:0]  num_nxt;
  logic              capture_c;
  logic              pop_c;
  logic              drop_c;
  logic              fifo_full_c;
  logic              fifo_empty_c;
  logic              busy_q;
  logic              done_q;
  logic              overflow_q;

  // Next-state, counter and capture-strobe logic.
  always_comb begin
    state_nxt = state;
    wait_nxt  = wait_cnt;
    cap_nxt   = cap_cnt;
    num_nxt   = num_q;
    capture_c = 1'b0;
    case (state)
      S_IDLE: begin
        if (i_start) begin
          num_nxt  = i_num_out;
          cap_nxt  = '0;
          wait_nxt = '0;
          if (i_num_out == '0) begin
            state_nxt = S_DONE;
          end else if (START_LATENCY == 1) begin
            state_nxt = S_CAPTURE;
          end else begin
            state_nxt = S_WAIT;
          end
        end
      end
      S_WAIT: begin
        if (wait_cnt == WAIT_W'(WAIT_LAST)) begin
          state_nxt = S_CAPTURE;
        end else begin
          wait_nxt = wait_cnt + WAIT_W'(1);
        end
      end
      S_CAPTURE: begin
        capture_c = 1'b1;
        if (cap_cnt + CNT_W'(1) == num_q) begin
          state_nxt = S_DONE;
        end else begin
          cap_nxt = cap_cnt + CNT_W'(1);
        end
      end
      S_DONE: begin
        state_nxt = S_IDLE;
      end
      default: begin
        state_nxt = S_IDLE;
      end
    endcase
    pop_c  = !fifo_empty_c && i_psum_ready;
    drop_c = capture_c && fifo_full_c && !pop_c;
  end

  // State, counters and registered status outputs.
  always_ff @(posedge i_clk or negedge i_rest_n) begin
    if (!i_rest_n) begin
      state      <= S_IDLE;
      wait_cnt   <= '0;
      cap_cnt    <= '0;
      num_q      <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      overflow_q <= 1'b0;
    end else begin
      state      <= state_nxt;
      wait_cnt   <= wait_nxt;
      cap_cnt    <= cap_nxt;
      num_q      <= num_nxt;
      busy_q     <= (state_nxt == S_WAIT) || (state_nxt == S_CAPTURE);
      done_q     <= (state_nxt == S_DONE);
      overflow_q <= overflow_q | drop_c;
    end
  end

  // Result FIFO between the column and the output stream.
  psum_fifo #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (FIFO_DEPTH)
  ) u_fifo (
    .clk     (i_clk),
    .rst_n   (i_rest_n),
    .push    (capture_c),
    .pop     (pop_c),
    .din     (i_psum),
    .head    (o_psum_data),
    .valid   (o_psum_valid),
    .count   (o_fifo_count),
    .full_c  (fifo_full_c),
    .empty_c (fifo_empty_c)
  );

  assign o_busy     = busy_q;
  assign o_done     = done_q;
  assign o_overflow = overflow_q;

endmodule

// File: tb/tb_mpe_psum_collector.sv
// Self-checking bench for mpe_psum_collector: table of directed passes,
// hand-written corner sequences and a random phase against a queue model.
module tb_mpe_psum_collector;

  localparam int unsigned DW = 32;
  localparam int unsigned CW = 8;
  localparam int unsigned LAT = 10;
  localparam int unsigned DEP = 4;
  localparam int unsigned FCW = 3;

  logic           i_clk;
  logic           i_rest_n;
  logic           i_start;
  logic [CW-1:0]  i_num_out;
  logic [DW-1:0]  i_psum;
  logic [DW-1:0]  o_psum_data;
  logic           o_psum_valid;
  logic           i_psum_ready;
  logic           o_busy;
  logic           o_done;
  logic           o_overflow;
  logic [FCW-1:0] o_fifo_count;

  mpe_psum_collector #(
    .DATA_WIDTH    (DW),
    .NUMBER_PE     (9),
    .START_LATENCY (LAT),
    .FIFO_DEPTH    (DEP),
    .CNT_W         (CW)
  ) dut (
    .i_clk        (i_clk),
    .i_rest_n     (i_rest_n),
    .i_start      (i_start),
    .i_num_out    (i_num_out),
    .i_psum       (i_psum),
    .o_psum_data  (o_psum_data),
    .o_psum_valid (o_psum_valid),
    .i_psum_ready (i_psum_ready),
    .o_busy       (o_busy),
    .o_done       (o_done),
    .o_overflow   (o_overflow),
    .o_fifo_count (o_fifo_count)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  int n_tests = 0;
  int n_fail  = 0;
  int done_seen;
  int done_e;

  // Reference model: a pass is an absolute-time window of capture edges.
  logic [DW-1:0] mq[$];
  bit            m_active;
  bit            m_done;
  bit            m_ov;
  int            m_t0;
  int            m_n;
  int            cyc;
  logic [DW-1:0] m_data;

  typedef struct {
    int n;
    bit rdy;
    int exp_cnt;
    bit exp_ov;
    int exp_data;
    int exp_done_e;
  } vec_t;
  vec_t vecs[7];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_clear();
    mq.delete();
    m_active = 1'b0;
    m_done   = 1'b0;
    m_ov     = 1'b0;
    m_t0     = 0;
    m_n      = 0;
    cyc      = 0;
    m_data   = '0;
  endtask

  task automatic model_step();
    bit pre_active;
    bit pre_done;
    bit pop;
    bit full_pre;
    bit fin;
    cyc++;
    pre_active = m_active;
    pre_done   = m_done;
    pop        = (mq.size() > 0) && (i_psum_ready == 1'b1);
    full_pre   = (mq.size() == int'(DEP));
    if (pop) void'(mq.pop_front());
    if (m_active && cyc >= m_t0 + int'(LAT) && cyc < m_t0 + int'(LAT) + m_n) begin
      if (!full_pre || pop) mq.push_back(i_psum);
      else m_ov = 1'b1;
    end
    fin = 1'b0;
    if (m_active && cyc == m_t0 + int'(LAT) + m_n - 1) begin
      m_active = 1'b0;
      fin = 1'b1;
    end
    if (!pre_active && !pre_done && i_start == 1'b1) begin
      if (i_num_out == '0) fin = 1'b1;
      else begin
        m_active = 1'b1;
        m_t0 = cyc;
        m_n = int'(i_num_out);
      end
    end
    m_done = fin;
    if (mq.size() > 0) m_data = mq[0];
  endtask

  task automatic model_check();
    chk("valid", 32'(o_psum_valid), 32'(mq.size() > 0));
    chk("data", o_psum_data, m_data);
    chk("count", 32'(o_fifo_count), 32'(mq.size()));
    chk("busy", 32'(o_busy), 32'(m_active));
    chk("done", 32'(o_done), 32'(m_done));
    chk("overflow", 32'(o_overflow), 32'(m_ov));
  endtask

  // One clock: model follows the edge, outputs checked at the falling edge.
  task automatic tick();
    @(posedge i_clk);
    if (i_rest_n) model_step();
    else model_clear();
    @(negedge i_clk);
    model_check();
    if (o_done === 1'b1) done_seen++;
  endtask

  task automatic do_reset();
    i_rest_n = 1'b0;
    i_start = 1'b0;
    i_psum_ready = 1'b0;
    i_psum = '0;
    i_num_out = '0;
    model_clear();
    repeat (3) tick();
    i_rest_n = 1'b1;
  endtask

  // Start a pass at the next edge (T0); psum = edge index relative to T0.
  task automatic run_pass(input int n, input bit rdy);
    i_num_out = CW'(n);
    i_start = 1'b1;
    i_psum_ready = rdy;
    i_psum = '0;
    done_seen = 0;
    done_e = -1;
    tick();
    if (o_done === 1'b1 && done_e < 0) done_e = 0;
    i_start = 1'b0;
    for (int e = 1; e <= int'(LAT) + n + 2; e++) begin
      i_psum = DW'(e);
      tick();
      if (o_done === 1'b1 && done_e < 0) done_e = e;
    end
  endtask

  initial begin
    vecs[0] = '{n: 9, rdy: 1'b1, exp_cnt: 0, exp_ov: 1'b0, exp_data: 18, exp_done_e: 18};
    vecs[1] = '{n: 6, rdy: 1'b0, exp_cnt: 4, exp_ov: 1'b1, exp_data: 10, exp_done_e: 15};
    vecs[2] = '{n: 4, rdy: 1'b0, exp_cnt: 4, exp_ov: 1'b0, exp_data: 10, exp_done_e: 13};
    vecs[3] = '{n: 0, rdy: 1'b0, exp_cnt: 0, exp_ov: 1'b0, exp_data: 0,  exp_done_e: 0};
    vecs[4] = '{n: 3, rdy: 1'b1, exp_cnt: 0, exp_ov: 1'b0, exp_data: 12, exp_done_e: 12};
    vecs[5] = '{n: 1, rdy: 1'b0, exp_cnt: 1, exp_ov: 1'b0, exp_data: 10, exp_done_e: 10};
    vecs[6] = '{n: 5, rdy: 1'b0, exp_cnt: 4, exp_ov: 1'b1, exp_data: 10, exp_done_e: 14};

    // Reset values and quiet release.
    do_reset();
    chk("rst_data", o_psum_data, 32'd0);
    chk("rst_valid", 32'(o_psum_valid), 32'd0);
    chk("rst_busy", 32'(o_busy), 32'd0);
    chk("rst_done", 32'(o_done), 32'd0);
    chk("rst_ovf", 32'(o_overflow), 32'd0);
    chk("rst_count", 32'(o_fifo_count), 32'd0);
    repeat (3) tick();
    chk("idle_busy", 32'(o_busy), 32'd0);
    chk("idle_count", 32'(o_fifo_count), 32'd0);

    // Table of single passes with constant ready.
    for (int i = 0; i < 7; i++) begin
      do_reset();
      run_pass(vecs[i].n, vecs[i].rdy);
      chk("vec_count", 32'(o_fifo_count), 32'(vecs[i].exp_cnt));
      chk("vec_ovf", 32'(o_overflow), 32'(vecs[i].exp_ov));
      chk("vec_data", o_psum_data, 32'(vecs[i].exp_data));
      chk("vec_done_once", 32'(done_seen), 32'd1);
      chk("vec_done_time", 32'(done_e), 32'(vecs[i].exp_done_e));
      chk("vec_busy", 32'(o_busy), 32'd0);
    end

    // Overflow then drain in order.
    do_reset();
    run_pass(6, 1'b0);
    chk("ovf_set", 32'(o_overflow), 32'd1);
    i_psum_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      chk("drain_valid", 32'(o_psum_valid), 32'd1);
      chk("drain_data", o_psum_data, 32'(10 + k));
      tick();
    end
    chk("drain_empty", 32'(o_psum_valid), 32'd0);
    chk("drain_hold", o_psum_data, 32'd13);
    chk("drain_ovf_sticky", 32'(o_overflow), 32'd1);

    // Capture into a full FIFO while popping on the same edge.
    do_reset();
    i_num_out = CW'(5);
    i_start = 1'b1;
    i_psum = '0;
    tick();
    i_start = 1'b0;
    for (int e = 1; e <= int'(LAT) + 6; e++) begin
      i_psum = DW'(e);
      i_psum_ready = (e == int'(LAT) + 4);
      tick();
    end
    chk("fullpop_count", 32'(o_fifo_count), 32'd4);
    chk("fullpop_ovf", 32'(o_overflow), 32'd0);
    i_psum_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      chk("fullpop_data", o_psum_data, 32'(11 + k));
      tick();
    end
    chk("fullpop_empty", 32'(o_psum_valid), 32'd0);

    // Second start during WAIT is ignored.
    do_reset();
    i_num_out = CW'(3);
    i_start = 1'b1;
    i_psum = '0;
    done_seen = 0;
    tick();
    i_start = 1'b0;
    for (int e = 1; e <= int'(LAT) + 8; e++) begin
      i_psum = DW'(e);
      i_start = (e == 3);
      i_num_out = (e == 3) ? CW'(7) : CW'(3);
      tick();
    end
    i_start = 1'b0;
    chk("busy_start_count", 32'(o_fifo_count), 32'd3);
    chk("busy_start_done", 32'(done_seen), 32'd1);
    chk("busy_start_head", o_psum_data, 32'd10);

    // Reset in the middle of CAPTURE after three pushes.
    do_reset();
    i_num_out = CW'(8);
    i_start = 1'b1;
    i_psum = '0;
    tick();
    i_start = 1'b0;
    for (int e = 1; e <= int'(LAT) + 2; e++) begin
      i_psum = DW'(e);
      tick();
    end
    chk("mid_pushes", 32'(o_fifo_count), 32'd3);
    i_rest_n = 1'b0;
    model_clear();
    #1;
    chk("mid_rst_count", 32'(o_fifo_count), 32'd0);
    chk("mid_rst_valid", 32'(o_psum_valid), 32'd0);
    chk("mid_rst_busy", 32'(o_busy), 32'd0);
    done_seen = 0;
    tick();
    i_rest_n = 1'b1;
    repeat (12) tick();
    chk("mid_no_done", 32'(done_seen), 32'd0);
    chk("mid_idle_count", 32'(o_fifo_count), 32'd0);

    // Random traffic against the model.
    do_reset();
    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(0, 599) == 0) begin
        i_rest_n = 1'b0;
        model_clear();
        tick();
        i_rest_n = 1'b1;
      end
      i_start = ($urandom_range(0, 7) == 0);
      i_num_out = CW'($urandom_range(0, 12));
      i_psum = DW'($urandom);
      i_psum_ready = ($urandom_range(0, 1) == 1);
      tick();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
